// File: rtl/shift_pkg.sv
// Shared types and helpers for the pipelined shifter: op encodings and
// the shift-amount width derived from the operand width.
package shift_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_ROL = 2'b10,
    OP_SRA = 2'b11
  } shift_op_e;

  localparam logic [1:0] ENC_SLL = 2'b00;
  localparam logic [1:0] ENC_SRL = 2'b01;
  localparam logic [1:0] ENC_ROL = 2'b10;
  localparam logic [1:0] ENC_SRA = 2'b11;

  function automatic int shamt_width(input int xlen);
    return (xlen > 1) ? $clog2(xlen) : 1;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// Combinational partial shifter: applies op with amount (amt << BASE).
// Chaining two of these with disjoint amount fields gives the full shift.
module shift_stage
  import shift_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int BASE = 0,
  parameter int NB   = 1
) (
  input  logic [XLEN-1:0] data,
  input  logic [NB-1:0]   amt,
  input  shift_op_e       op,
  output logic [XLEN-1:0] result
);

  localparam int SHW = shamt_width(XLEN);

  logic [SHW-1:0] k;
  assign k = SHW'(amt) << BASE;

  always_comb begin
    result = data;
    case (op)
      OP_SLL: result = data << k;
      OP_SRL: result = data >> k;
      OP_SRA: result = XLEN'($signed(data) >>> k);
      // a shift by XLEN yields zero, so k = 0 leaves data untouched
      OP_ROL: result = (data << k) | (data >> (XLEN - int'(k)));
      default: result = data;
    endcase
  end

endmodule

// File: rtl/shift_pipe.sv
// Two-stage pipelined shifter with valid/ready handshake, backpressure
// and flush. Stage 1 resolves the low shamt bits, stage 2 the high bits.
module shift_pipe
  import shift_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int SHW = shamt_width(XLEN),
  localparam int LO  = SHW / 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_data,
  input  logic [SHW-1:0]  in_shamt,
  input  logic [1:0]      in_op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data
);

  shift_op_e             op_in;
  logic [XLEN-1:0]       s1_next;
  logic [XLEN-1:0]       s2_next;
  logic                  s1_valid;
  logic [XLEN-1:0]       s1_data;
  shift_op_e             s1_op;
  logic [SHW-LO-1:0]     s1_hi;
  logic                  s2_valid;
  logic [XLEN-1:0]       s2_data;
  logic                  adv1;
  logic                  adv2;

  assign op_in = shift_op_e'(in_op);

  shift_stage #(.XLEN(XLEN), .BASE(0), .NB(LO)) u_stage1 (
    .data   (in_data),
    .amt    (in_shamt[LO-1:0]),
    .op     (op_in),
    .result (s1_next)
  );

  shift_stage #(.XLEN(XLEN), .BASE(LO), .NB(SHW - LO)) u_stage2 (
    .data   (s1_data),
    .amt    (s1_hi),
    .op     (s1_op),
    .result (s2_next)
  );

  assign adv2     = !s2_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1 && !flush;

  assign out_valid = s2_valid;
  assign out_data  = s2_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_data  <= '0;
      s1_op    <= OP_SLL;
      s1_hi    <= '0;
      s2_data  <= '0;
    end else begin
      if (flush) begin
        s1_valid <= 1'b0;
        s2_valid <= 1'b0;
      end else begin
        if (adv2) s2_valid <= s1_valid;
        if (adv1) s1_valid <= in_valid;
      end
      if (in_valid && in_ready) begin
        s1_data <= s1_next;
        s1_op   <= op_in;
        s1_hi   <= in_shamt[SHW-1:LO];
      end
      // out_data must stay put while the consumer stalls
      if (adv2 && s1_valid && !flush) s2_data <= s2_next;
    end
  end

endmodule

// File: tb/tb_shift_pipe.sv
// Directed bench for shift_pipe at XLEN = 32, followed by a randomized
// run with stalls checked against a scoreboard of reference results.
module tb_shift_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] q[$];

  shift_pipe #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] s, input logic [1:0] op);
    in_valid = v;
    in_data  = d;
    in_shamt = s;
    in_op    = op;
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s, input logic [1:0] op);
    logic [63:0] w;
    case (op)
      2'b00:   return d << s;
      2'b01:   return d >> s;
      2'b11:   return 32'($signed(d) >>> s);
      default: begin
        w = {d, d} << s;
        return w[63:32];
      end
    endcase
  endfunction

  // Present one op with the pipe empty; result must show two edges later.
  task automatic run_op(input string tag, input logic [31:0] d, input logic [4:0] s,
                        input logic [1:0] op, input logic [31:0] exp);
    out_ready = 1'b1;
    drive(1'b1, d, s, op);
    #1;
    check({tag, "_in_ready"}, in_ready, 1'b1);
    tick();
    drive(1'b0, 32'h0, 5'd0, 2'b00);
    #1;
    check({tag, "_early"}, out_valid, 1'b0);
    tick();
    #1;
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_data"}, out_data, exp);
    $display("op %s: data=%h shamt=%0d op=%b -> %h", tag, d, s, op, out_data);
    tick();
  endtask

  initial begin
    rst = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 32'h0, 5'd0, 2'b00);
    #2 rst = 1'b1;
    #1;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_data", out_data, 32'h0);
    tick();
    rst = 1'b0;
    #1;
    check("reset_in_ready", in_ready, 1'b1);
    tick();

    // basic ops and boundaries
    run_op("sll31", 32'h00000001, 5'd31, 2'b00, 32'h80000000);
    run_op("srl28", 32'hF0000000, 5'd28, 2'b01, 32'h0000000F);
    run_op("sra4",  32'h80000000, 5'd4,  2'b11, 32'hF8000000);
    run_op("rol1",  32'h80000001, 5'd1,  2'b10, 32'h00000003);
    run_op("rol20", 32'h12345678, 5'd20, 2'b10, 32'h67812345);
    run_op("sll0",  32'hA5A5A5A5, 5'd0,  2'b00, 32'hA5A5A5A5);
    run_op("srl0",  32'hA5A5A5A5, 5'd0,  2'b01, 32'hA5A5A5A5);
    run_op("sra0",  32'hA5A5A5A5, 5'd0,  2'b11, 32'hA5A5A5A5);
    run_op("rol0",  32'hA5A5A5A5, 5'd0,  2'b10, 32'hA5A5A5A5);
    run_op("sra31", 32'h7FFFFFFF, 5'd31, 2'b11, 32'h00000000);

    // backpressure: out_ready low for three cycles, four requests
    out_ready = 1'b0;
    drive(1'b1, 32'h12345678, 5'd4, 2'b10);
    #1; check("bp_accept_a", in_ready, 1'b1);
    tick();
    drive(1'b1, 32'h12345678, 5'd8, 2'b01);
    #1; check("bp_accept_b", in_ready, 1'b1);
    check("bp_b_out_valid", out_valid, 1'b0);
    tick();
    drive(1'b1, 32'h87654321, 5'd12, 2'b11);
    #1; check("bp_full_in_ready", in_ready, 1'b0);
    check("bp_hold_a", out_data, 32'h23456781);
    tick();
    #1; check("bp_still_full", in_ready, 1'b0);
    out_ready = 1'b1;
    #1; check("bp_release_in_ready", in_ready, 1'b1);
    check("bp_out_a", out_data, 32'h23456781);
    tick();
    drive(1'b1, 32'h0000ABCD, 5'd16, 2'b00);
    #1; check("bp_out_b", out_data, 32'h00123456);
    check("bp_accept_d", in_ready, 1'b1);
    tick();
    drive(1'b0, 32'h0, 5'd0, 2'b00);
    #1; check("bp_out_c", out_data, 32'hFFF87654);
    check("bp_c_valid", out_valid, 1'b1);
    tick();
    #1; check("bp_out_d", out_data, 32'hABCD0000);
    check("bp_d_valid", out_valid, 1'b1);
    tick();
    #1; check("bp_empty", out_valid, 1'b0);
    $display("backpressure sequence done");

    // flush with two ops in flight and a request dropped during the flush
    out_ready = 1'b1;
    drive(1'b1, 32'h0000000F, 5'd4, 2'b00);
    tick();
    drive(1'b1, 32'h000000FF, 5'd8, 2'b00);
    tick();
    drive(1'b1, 32'h00000001, 5'd1, 2'b00);
    flush = 1'b1;
    #1; check("flush_in_ready", in_ready, 1'b0);
    check("flush_s2_valid", out_valid, 1'b1);
    check("flush_s2_data", out_data, 32'h000000F0);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 2'b00);
    #1; check("flush_empty1", out_valid, 1'b0);
    tick();
    #1; check("flush_empty2", out_valid, 1'b0);
    tick();
    #1; check("flush_empty3", out_valid, 1'b0);
    $display("flush sequence done");

    // asynchronous reset with both stages full
    out_ready = 1'b0;
    drive(1'b1, 32'h11111111, 5'd1, 2'b00);
    tick();
    drive(1'b1, 32'h22222222, 5'd2, 2'b00);
    tick();
    drive(1'b0, 32'h0, 5'd0, 2'b00);
    #1; check("mid_full_valid", out_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("mid_reset_out_valid", out_valid, 1'b0);
    check("mid_reset_out_data", out_data, 32'h0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    #1; check("mid_reset_in_ready", in_ready, 1'b1);
    tick();
    #1; check("mid_reset_no_output", out_valid, 1'b0);
    $display("mid-stream reset done");

    // randomized traffic with random stalls
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 3) != 0), $urandom, 5'($urandom_range(0, 31)), 2'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("rand_unexpected", out_valid, 1'b0);
        else check("rand_data", out_data, q.pop_front());
      end
      if (in_valid && in_ready) q.push_back(ref_shift(in_data, in_shamt, in_op));
      tick();
    end
    drive(1'b0, 32'h0, 5'd0, 2'b00);
    out_ready = 1'b1;
    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      #1;
      if (out_valid) check("rand_drain_data", out_data, q.pop_front());
      tick();
    end
    check("rand_drain_empty", q.size(), 0);
    $display("random traffic done");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
